// File: rtl/sci_pkg.sv
// ----------------------------------------------------------------------------
// sci_pkg
// Shared constants for the FIFO-buffered SCI (sci_fifo_uart).
// Contents:
//   - bus register addresses
//   - status bit positions
//   - RX/TX state encodings
//   - baud divider helper
// No ports (package).
// ----------------------------------------------------------------------------
package sci_pkg;

    localparam logic [2:0] ADDR_STAT    = 3'd4;
    localparam logic [2:0] ADDR_DATA_RD = 3'd5;
    localparam logic [2:0] ADDR_DATA_WR = 3'd6;
    localparam logic [2:0] ADDR_RXCNT   = 3'd7;

    localparam int STAT_TX_NFULL  = 7;
    localparam int STAT_TX_IDLE   = 6;
    localparam int STAT_PERR      = 3;
    localparam int STAT_FERR      = 2;
    localparam int STAT_OVR       = 1;
    localparam int STAT_RX_NEMPTY = 0;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    // Clocks per 16x oversample tick, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

endpackage

// File: rtl/sci_fifo_uart_if.sv
// ----------------------------------------------------------------------------
// sci_fifo_uart_if
// MiniS08 IOsel bus as seen by the SCI.
// Signals:
//   IOsel   peripheral select
//   addr    register address (3 bits)
//   read    read strobe (level)
//   write   write strobe (level)
//   datain  write data (8 bits)
//   dataout read data (8 bits), 0 when not selected for read
// Modports: master (CPU side), slave (peripheral side).
// ----------------------------------------------------------------------------
interface sci_fifo_uart_if;
    logic       IOsel;
    logic [2:0] addr;
    logic       read;
    logic       write;
    logic [7:0] datain;
    logic [7:0] dataout;

    modport master (output IOsel, output addr, output read, output write,
                    output datain, input dataout);
    modport slave  (input IOsel, input addr, input read, input write,
                    input datain, output dataout);
endinterface

// File: rtl/sci_sync_fifo.sv
// ----------------------------------------------------------------------------
// sci_sync_fifo
// Single-clock FIFO used for both the SCI TX and RX queues.
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_data (ignored when full unless popping same clk)
//   i_data       entry to write
//   i_pop        drop head entry (ignored when empty)
//   o_data       current head entry
//   o_count      fill level, 0..DEPTH
// ----------------------------------------------------------------------------
module sci_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A pop frees a slot in the same clk, so a full FIFO still accepts a push then.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/sci_fifo_uart.sv
// ----------------------------------------------------------------------------
// sci_fifo_uart
// FIFO-buffered 8N1 serial port on the MiniS08 IOsel bus.
// Parameters: CLK_HZ, BAUD, DEPTH (FIFO entries), DATA_BITS (5..8).
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sci_fifo_uart_if.slave: 4=status rd, 5=data rd, 6=data wr, 7=RX count rd
//   rxd    serial input (asynchronous to clk)
//   txd    serial output, idle high
// Optional feature: define SCI_PARITY_EN to add one even-parity bit after the
// data bits on both TX and RX; status[3] then reports RX parity mismatches.
// ----------------------------------------------------------------------------
module sci_fifo_uart
    import sci_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DEPTH     = 8,
    parameter int DATA_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sci_fifo_uart_if.slave    bus,
    input  logic              rxd,
    output logic              txd
);
    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;

    // ---------------- bus decode: one side effect per strobe assertion
    logic w_rd_stat, w_rd_data, w_wr_data;
    logic r_rd_stat_d, r_rd_data_d, r_wr_data_d;
    logic w_stat_clr, w_rx_pop, w_tx_push;

    assign w_rd_stat = bus.IOsel && bus.read  && (bus.addr == ADDR_STAT);
    assign w_rd_data = bus.IOsel && bus.read  && (bus.addr == ADDR_DATA_RD);
    assign w_wr_data = bus.IOsel && bus.write && (bus.addr == ADDR_DATA_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_stat_d <= 1'b0;
            r_rd_data_d <= 1'b0;
            r_wr_data_d <= 1'b0;
        end else begin
            r_rd_stat_d <= w_rd_stat;
            r_rd_data_d <= w_rd_data;
            r_wr_data_d <= w_wr_data;
        end
    end

    assign w_stat_clr = w_rd_stat && !r_rd_stat_d;
    assign w_rx_pop   = w_rd_data && !r_rd_data_d;
    assign w_tx_push  = w_wr_data && !r_wr_data_d;

    // ---------------- baud: tick16 every DIV clks, bit tick every 16th tick16
    logic [BW-1:0] r_baud_cnt;
    logic [3:0]    r_tick_sub;
    logic          w_tick16, w_bit_tick;

    assign w_tick16   = (r_baud_cnt == BW'(DIV - 1));
    assign w_bit_tick = w_tick16 && (r_tick_sub == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_tick_sub <= '0;
        end else if (w_tick16) begin
            r_baud_cnt <= '0;
            r_tick_sub <= r_tick_sub + 4'd1;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    // ---------------- FIFOs
    logic [DATA_BITS-1:0] w_tx_head, w_rx_head, r_rx_shift;
    logic [CW-1:0]        w_tx_count, w_rx_count;
    logic                 w_tx_pop, w_rx_push, w_tx_empty, w_rx_empty, w_rx_full;

    sci_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .i_push(w_tx_push), .i_data(bus.datain[DATA_BITS-1:0]),
        .i_pop(w_tx_pop), .o_data(w_tx_head), .o_count(w_tx_count));

    sci_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .i_push(w_rx_push), .i_data(r_rx_shift),
        .i_pop(w_rx_pop), .o_data(w_rx_head), .o_count(w_rx_count));

    assign w_tx_empty = (w_tx_count == '0);
    assign w_rx_empty = (w_rx_count == '0);
    assign w_rx_full  = (w_rx_count == CW'(DEPTH));

    // ---------------- TX FSM
    tx_state_t            r_tx_state;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [2:0]           r_tx_bit;
    logic                 r_txd, r_tx_done;
`ifdef SCI_PARITY_EN
    logic                 r_tx_par;
`endif

    // Loading from STOP as well as IDLE keeps back-to-back frames gapless.
    assign w_tx_pop = w_bit_tick && !w_tx_empty &&
                      ((r_tx_state == TX_IDLE) || (r_tx_state == TX_STOP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_txd      <= 1'b1;
            r_tx_done  <= 1'b0;
`ifdef SCI_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            if (w_tx_push) r_tx_done <= 1'b0;
            if (w_bit_tick) begin
                case (r_tx_state)
                    TX_IDLE, TX_STOP: begin
                        if (!w_tx_empty) begin
                            r_tx_shift <= w_tx_head;
`ifdef SCI_PARITY_EN
                            r_tx_par   <= ^w_tx_head;
`endif
                            r_txd      <= 1'b0;
                            r_tx_state <= TX_START;
                        end else begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_IDLE;
                            // Done flag marks "last stop bit fully sent, nothing queued".
                            if (r_tx_state == TX_STOP && !w_tx_push) r_tx_done <= 1'b1;
                        end
                    end
                    TX_START: begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (r_tx_bit == 3'(DATA_BITS - 1)) begin
`ifdef SCI_PARITY_EN
                            r_txd      <= r_tx_par;
                            r_tx_state <= TX_PARITY;
`else
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
`endif
                        end else begin
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end
                    TX_PARITY: begin
                        r_txd      <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign txd = r_txd;

    // ---------------- RX synchroniser and FSM
    rx_state_t  r_rx_state;
    logic       r_rx_s1, r_rx_s2, r_rx_prev;
    logic [3:0] r_rx_os;
    logic [2:0] r_rx_bit;
    logic       w_rx_stop_smp, w_ferr_set, w_ovr_set;
`ifdef SCI_PARITY_EN
    logic       r_rx_perr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // START waits 8 ticks to reach mid start bit; later samples are 16 ticks apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_os    <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
`ifdef SCI_PARITY_EN
            r_rx_perr  <= 1'b0;
`endif
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_os    <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_tick16) begin
                        if (r_rx_os == 4'd7) begin
                            r_rx_os    <= '0;
                            r_rx_bit   <= '0;
                            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            r_rx_os <= r_rx_os + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_tick16) begin
                        r_rx_os <= r_rx_os + 4'd1;
                        if (r_rx_os == 4'hF) begin
                            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                            if (r_rx_bit == 3'(DATA_BITS - 1)) begin
`ifdef SCI_PARITY_EN
                                r_rx_state <= RX_PARITY;
`else
                                r_rx_state <= RX_STOP;
`endif
                            end else begin
                                r_rx_bit <= r_rx_bit + 3'd1;
                            end
                        end
                    end
                end
`ifdef SCI_PARITY_EN
                RX_PARITY: begin
                    if (w_tick16) begin
                        r_rx_os <= r_rx_os + 4'd1;
                        if (r_rx_os == 4'hF) begin
                            r_rx_perr  <= (^r_rx_shift) ^ r_rx_s2;
                            r_rx_state <= RX_STOP;
                        end
                    end
                end
`endif
                RX_STOP: begin
                    if (w_tick16) begin
                        r_rx_os <= r_rx_os + 4'd1;
                        if (r_rx_os == 4'hF) r_rx_state <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign w_rx_stop_smp = w_tick16 && (r_rx_state == RX_STOP) && (r_rx_os == 4'hF);
    assign w_rx_push     = w_rx_stop_smp && r_rx_s2;
    assign w_ferr_set    = w_rx_stop_smp && !r_rx_s2;
    // A same-clk pop makes room, so that case is not an overrun.
    assign w_ovr_set     = w_rx_push && w_rx_full && !w_rx_pop;

    // ---------------- sticky flags: set beats clear on the same clk
    logic r_ferr, r_ovr;
`ifdef SCI_PARITY_EN
    logic r_perr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
`ifdef SCI_PARITY_EN
            r_perr <= 1'b0;
`endif
        end else begin
            r_ferr <= w_ferr_set | (r_ferr & !w_stat_clr);
            r_ovr  <= w_ovr_set  | (r_ovr  & !w_stat_clr);
`ifdef SCI_PARITY_EN
            r_perr <= (w_rx_push & r_rx_perr) | (r_perr & !w_stat_clr);
`endif
        end
    end

    // ---------------- read mux
    logic [7:0] w_status, w_rx_head8, w_rx_cnt8;

    always_comb begin
        w_status                 = '0;
        w_status[STAT_TX_NFULL]  = (w_tx_count != CW'(DEPTH));
        w_status[STAT_TX_IDLE]   = r_tx_done;
`ifdef SCI_PARITY_EN
        w_status[STAT_PERR]      = r_perr;
`endif
        w_status[STAT_FERR]      = r_ferr;
        w_status[STAT_OVR]       = r_ovr;
        w_status[STAT_RX_NEMPTY] = !w_rx_empty;

        w_rx_head8                  = '0;
        w_rx_head8[DATA_BITS-1:0]   = w_rx_head;
        w_rx_cnt8                   = '0;
        w_rx_cnt8[CW-1:0]           = w_rx_count;

        bus.dataout = '0;
        if (bus.IOsel && bus.read) begin
            case (bus.addr)
                ADDR_STAT:    bus.dataout = w_status;
                ADDR_DATA_RD: bus.dataout = w_rx_empty ? 8'h00 : w_rx_head8;
                ADDR_RXCNT:   bus.dataout = w_rx_cnt8;
                default:      bus.dataout = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_sci_fifo_uart.sv
module tb_sci_fifo_uart;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic txd;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   tick_ref = 0;

    sci_fifo_uart_if bus();

    sci_fifo_uart #(.CLK_HZ(1_600_000), .BAUD(100_000), .DEPTH(4), .DATA_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .rxd(rxd), .txd(txd));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.IOsel = 1'b1; bus.addr = a; bus.datain = d; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0; bus.IOsel = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.IOsel = 1'b1; bus.addr = a; bus.read = 1'b1;
        #1 d = bus.dataout;
        @(negedge clk);
        bus.read = 1'b0; bus.IOsel = 1'b0;
    endtask

    task automatic wait_txd_low(output int n, output bit ok);
        ok = 1'b0; n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin n = cyc; ok = 1'b1; return; end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = fr[i];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        bus.IOsel = 1'b0; bus.addr = 3'd0; bus.read = 1'b0; bus.write = 1'b0; bus.datain = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
        checks++; if (bus.dataout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", bus.dataout); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(3'd4, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL reset_status got %h exp 80", d); end
        bus_read(3'd7, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_rxcnt got %h exp 00", d); end
        bus_read(3'd5, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_rxdata got %h exp 00", d); end
        @(negedge clk);
        bus.IOsel = 1'b0; bus.addr = 3'd4; bus.read = 1'b1;
        #1;
        checks++; if (bus.dataout !== 8'h00) begin errors++; $display("FAIL unsel_read got %h exp 00", bus.dataout); end
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    task automatic test_tx_single();
        logic [7:0] d;
        logic [7:0] b;
        logic       exp_bit, a0, a1;
        int         n0;
        bit         ok;
        b = 8'h55;
        bus_write(3'd6, b);
        wait_txd_low(n0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tx1_start got timeout exp low"); return; end
        tick_ref = n0;
        for (int i = 0; i < 10; i++) begin
            exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            wait_until(n0 + 16 * i);
            a0 = txd;
            wait_until(n0 + 16 * i + 15);
            a1 = txd;
            checks++;
            if (a0 !== exp_bit || a1 !== exp_bit) begin
                errors++; $display("FAIL tx1_bit%0d got %b%b exp %b", i, a0, a1, exp_bit);
            end
        end
        wait_until(n0 + 161);
        bus_read(3'd4, d);
        checks++; if (d !== 8'hC0) begin errors++; $display("FAIL tx1_status got %h exp c0", d); end
    endtask

    task automatic test_tx_fifo_full();
        logic [7:0] vals [5];
        logic [7:0] d;
        logic [9:0] fr;
        int         t, n1;
        bit         ok;
        vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        t = tick_ref + 16 * ((cyc - tick_ref) / 16 + 1);
        wait_until(t);
        for (int i = 0; i < 5; i++) bus_write(3'd6, vals[i]);
        bus_read(3'd4, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL txf_full_status got %h exp 00", d); end
        wait_txd_low(n1, ok);
        checks++;
        if (!ok || n1 != t + 16) begin
            errors++; $display("FAIL txf_start got %0d exp %0d", n1 - t, 16); return;
        end
        bus_read(3'd4, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL txf_after_pop got %h exp 80", d); end
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 10; i++) begin
                wait_until(n1 + 160 * f + 16 * i + 8);
                fr[i] = txd;
            end
            checks++;
            if (fr !== {1'b1, vals[f], 1'b0}) begin
                errors++; $display("FAIL txf_frame%0d got %h exp %h", f, fr, {1'b1, vals[f], 1'b0});
            end
        end
        wait_until(n1 + 648);
        fr[0] = txd;
        wait_until(n1 + 680);
        fr[1] = txd;
        checks++;
        if (fr[1:0] !== 2'b11) begin errors++; $display("FAIL txf_dropped got %b exp 11", fr[1:0]); end
        bus_read(3'd4, d);
        checks++; if (d !== 8'hC0) begin errors++; $display("FAIL txf_done got %h exp c0", d); end
    endtask

    task automatic test_rx_single();
        logic [7:0] d;
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(3'd4, d);
        checks++; if (d !== 8'hC1) begin errors++; $display("FAIL rx1_status got %h exp c1", d); end
        bus_read(3'd7, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL rx1_count got %h exp 01", d); end
        bus_read(3'd5, d);
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rx1_data got %h exp 3c", d); end
        bus_read(3'd4, d);
        checks++; if (d !== 8'hC0) begin errors++; $display("FAIL rx1_status2 got %h exp c0", d); end
        bus_read(3'd7, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rx1_count2 got %h exp 00", d); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] vals [5];
        logic [7:0] d;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) send_rx(vals[i], 1'b1);
        repeat (4) @(negedge clk);
        bus_read(3'd4, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL ovr_status got %h exp c3", d); end
        bus_read(3'd4, d);
        checks++; if (d !== 8'hC1) begin errors++; $display("FAIL ovr_cleared got %h exp c1", d); end
        bus_read(3'd7, d);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL ovr_count got %h exp 04", d); end
        for (int i = 0; i < 4; i++) begin
            bus_read(3'd5, d);
            checks++; if (d !== vals[i]) begin errors++; $display("FAIL ovr_data%0d got %h exp %h", i, d, vals[i]); end
        end
        bus_read(3'd7, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovr_count2 got %h exp 00", d); end
        bus_read(3'd5, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovr_empty_rd got %h exp 00", d); end
    endtask

    task automatic test_rx_errors();
        logic [7:0] d;
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(3'd7, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL glitch_count got %h exp 00", d); end
        bus_read(3'd4, d);
        checks++; if (d !== 8'hC0) begin errors++; $display("FAIL glitch_status got %h exp c0", d); end
        send_rx(8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        bus_read(3'd4, d);
        checks++; if (d !== 8'hC4) begin errors++; $display("FAIL ferr_status got %h exp c4", d); end
        bus_read(3'd7, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ferr_count got %h exp 00", d); end
        bus_read(3'd4, d);
        checks++; if (d !== 8'hC0) begin errors++; $display("FAIL ferr_cleared got %h exp c0", d); end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        int         n;
        bit         ok;
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(3'd7, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL rst_pre_count got %h exp 01", d); end
        bus_write(3'd6, 8'hF0);
        bus_write(3'd6, 8'h77);
        wait_txd_low(n, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_tx_start got timeout exp low"); return; end
        repeat (20) @(negedge clk);
        checks++; if (txd !== 1'b0) begin errors++; $display("FAIL rst_pre_txd got %b exp 0", txd); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_async_txd got %b exp 1", txd); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(3'd4, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL rst_status got %h exp 80", d); end
        bus_read(3'd7, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_count got %h exp 00", d); end
        repeat (40) @(negedge clk);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_tx_idle got %b exp 1", txd); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_fifo_full();
        test_rx_single();
        test_rx_overrun();
        test_rx_errors();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
